// File: rtl/stream_checker_pkg.sv
// stream_checker_pkg: shared state encoding and constants for the stream checker sink.
package stream_checker_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, FINISH} state_t;
  localparam int DEF_PERIOD_W = 16;
  localparam logic [31:0] NO_ERR_IDX = 32'hFFFFFFFF;
endpackage

// File: rtl/stream_checker_if.sv
// stream_checker_if: configuration, data stream and result bundle of the stream checker.
interface stream_checker_if import stream_checker_pkg::*; #(parameter int PERIOD_W = DEF_PERIOD_W);
  logic running;
  logic run;
  logic [31:0] iterations;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] duty;
  logic [31:0] start;
  logic [31:0] shift;
  logic [31:0] incr;
  logic [31:0] delay0;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [31:0] out1;
  logic [31:0] out2;
  logic done;
  modport master (output running, run, iterations, period, duty, start, shift, incr, delay0, in0,
                  input out0, out1, out2, done);
  modport slave (input running, run, iterations, period, duty, start, shift, incr, delay0, in0,
                 output out0, out1, out2, done);
endinterface

// File: rtl/stream_checker_pattern_timer.sv
// stream_checker_pattern_timer: Generator-compatible delay/phase/iteration schedule for sink units.
module stream_checker_pattern_timer import stream_checker_pkg::*; #(parameter int PERIOD_W = DEF_PERIOD_W) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [31:0]         iterations,
  input  logic [31:0]         delay0,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] duty,
  output logic                sample_en,
  output logic                period_end,
  output logic                pass_end
);
  state_t state_q, state_d;
  logic [31:0] iters_q, iters_d, delay_q, delay_d, dcnt_q, dcnt_d, iter_q, iter_d;
  logic [PERIOD_W-1:0] per_q, per_d, duty_q, duty_d, phase_q, phase_d;
  logic degen;
  assign sample_en  = state_q == ACTIVE && phase_q < duty_q;
  assign period_end = state_q == ACTIVE && phase_q == per_q - 1'b1;
  assign pass_end   = state_q == FINISH;
  always_comb begin
    per_d   = run ? period : per_q;
    duty_d  = run ? (duty < period ? duty : period) : duty_q;
    iters_d = run ? iterations : iters_q;
    delay_d = run ? delay0 : delay_q;
    degen   = iters_d == '0 || per_d == '0;
    dcnt_d  = run ? '0 : dcnt_q + 32'(state_q == DELAY);
    phase_d = run || period_end ? '0 : phase_q + PERIOD_W'(state_q == ACTIVE);
    iter_d  = run ? '0 : iter_q + 32'(period_end);
    state_d = state_q;
    if (run)
      state_d = delay0 != '0 ? DELAY : degen ? FINISH : ACTIVE;
    else
      case (state_q)
        DELAY:   if (dcnt_q == delay_q - 1) state_d = degen ? FINISH : ACTIVE;
        ACTIVE:  if (period_end && iter_q == iters_q - 1) state_d = FINISH;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      iters_q <= '0;
      delay_q <= '0;
      dcnt_q  <= '0;
      iter_q  <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      iters_q <= iters_d;
      delay_q <= delay_d;
      dcnt_q  <= dcnt_d;
      iter_q  <= iter_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      phase_q <= phase_d;
    end
endmodule

// File: rtl/stream_checker.sv
// stream_checker: compares sampled in0 against a start/incr/shift sequence, counts errors and sums data.
module stream_checker import stream_checker_pkg::*; #(parameter int PERIOD_W = DEF_PERIOD_W) (
  input logic           clk,
  input logic           rst,
  stream_checker_if.slave bus
);
  logic sample_en, period_end, pass_end, mism, unused;
  logic [31:0] incr_q, incr_d, shift_q, shift_d, exp_q, exp_d, err_q, err_d;
  logic [31:0] sum_q, sum_d, idx_q, idx_d, first_q, first_d, exp_s;
  logic done_q, done_d;
  stream_checker_pattern_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk(clk), .rst(rst), .run(bus.run), .iterations(bus.iterations), .delay0(bus.delay0),
    .period(bus.period), .duty(bus.duty), .sample_en(sample_en), .period_end(period_end),
    .pass_end(pass_end)
  );
  assign unused = bus.running;
  always_comb begin
    mism    = sample_en && bus.in0 != exp_q;
    exp_s   = exp_q + (sample_en ? incr_q : '0);
    incr_d  = bus.run ? bus.incr : incr_q;
    shift_d = bus.run ? bus.shift : shift_q;
    exp_d   = bus.run ? bus.start : period_end ? exp_s + shift_q : exp_s;
    sum_d   = bus.run ? '0 : sum_q + (sample_en ? bus.in0 : '0);
    err_d   = bus.run ? '0 : mism && err_q != '1 ? err_q + 1 : err_q;
    // err_q never returns to zero once set, so zero marks the first mismatch
    first_d = bus.run ? NO_ERR_IDX : mism && err_q == '0 ? idx_q : first_q;
    idx_d   = bus.run ? '0 : idx_q + 32'(sample_en);
    done_d  = bus.run ? 1'b0 : done_q | pass_end;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      incr_q  <= '0;
      shift_q <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      first_q <= NO_ERR_IDX;
      done_q  <= 1'b1;
    end else begin
      incr_q  <= incr_d;
      shift_q <= shift_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  assign bus.out0 = err_q;
  assign bus.out1 = sum_q;
  assign bus.out2 = first_q;
  assign bus.done = done_q;
endmodule
